iob_asym_fifo_w_narrow_r_wide_ctrl: RTL and testbench
=====================================================

// Module: iob_asym_fifo_w_narrow_r_wide_ctrl
// PURPOSE
//  Single-clock FIFO controller sequencing an external narrow-write/wide-read two-port RAM.
//  - Accepts narrow words on the push side; releases one wide word (RATIO narrow words) per pop.
//  - Owns the pointers, occupancy level and full/empty flags, plus read-data valid timing.
//  - Sits between a byte/word stream producer and a wider consumer; the RAM is instantiated by the parent.
// PARAMETERS
//  W_DATA_W  8   narrow (write) data width
//  R_DATA_W  32  wide (read) data width; integer multiple of W_DATA_W, RATIO=R_DATA_W/W_DATA_W a power of 2
//  W_ADDR_W  6   narrow address width; depth = 2**W_ADDR_W narrow words
//  R_ADDR_W  derived = W_ADDR_W - log2(RATIO); must not be overridden
// PORTS
//  clk          in   1         clock, all logic on rising edge
//  arst_n       in   1         asynchronous reset, active low
//  rst          in   1         synchronous clear (pointers, level, valid)
//  w_en         in   1         push request
//  w_data       in   W_DATA_W  push data
//  w_full       out  1         no room for another narrow word
//  r_en         in   1         pop request (one wide word)
//  r_data       out  R_DATA_W  popped wide word (from RAM)
//  r_data_valid out  1         r_data holds the word popped last cycle
//  r_empty      out  1         fewer than RATIO narrow words stored
//  level        out  W_ADDR_W+1 occupancy in narrow words
//  ext_mem_w_en   out 1        RAM write enable
//  ext_mem_w_addr out W_ADDR_W RAM write address
//  ext_mem_w_data out W_DATA_W RAM write data
//  ext_mem_r_en   out 1        RAM read enable
//  ext_mem_r_addr out R_ADDR_W RAM read address
//  ext_mem_r_data in  R_DATA_W RAM read data (1-cycle registered read)
// BEHAVIOUR
//  - Reset (arst_n=0 or rst=1): w_ptr=0, r_ptr=0, level=0, w_full=0, r_empty=1, r_data_valid=0.
//  - Push accepted iff w_en & !w_full: ext_mem_w_en=1, addr=w_ptr, data=w_data (combinational
//    pass-through); w_ptr+=1 mod 2**W_ADDR_W. Push while full: dropped, no pointer/level change.
//  - Pop accepted iff r_en & !r_empty: ext_mem_r_en=1, addr=r_ptr; r_ptr+=1 mod 2**R_ADDR_W.
//    Pop while empty: ignored, ext_mem_r_en=0.
//  - Latency: r_data_valid=1 exactly the cycle after an accepted pop; r_data=ext_mem_r_data.
//  - Lane order: first-pushed narrow word of a group lands in r_data[W_DATA_W-1:0], last in MSBs.
//  - level update per cycle: +1 push only, -RATIO pop only, +1-RATIO both; never wraps.
//  - Flags registered from next level: w_full = (level==2**W_ADDR_W); r_empty = (level<RATIO).
//  - Simultaneous push+pop when full: pop accepted, push dropped (flag is pre-cycle).
//  - Pushed data is visible to a pop no earlier than 1 cycle after the level update (no RAW hazard).
//  - Pointer wrap: both wrap naturally; w_ptr>>log2(RATIO) == r_ptr when level==0.
//  - rst mid-transfer: outstanding r_data_valid cleared next cycle; RAM contents untouched.
// STRUCTURE
//  - Shared header iob_asym_fifo.vh: `max/`min macros, RATIO/log2RATIO localparam derivation.
//  - One sub-module: iob_asym_fifo_level (up/down level counter, inc 1 / dec RATIO, flag outputs).
//  - Pointers and valid register live in the top; no FSM beyond counters.
// TESTING (bench wraps controller + t2p asym RAM, W=8, R=32, W_ADDR_W=4)
//  1 Reset: after arst_n release -> level=0, r_empty=1, w_full=0, r_data_valid=0.
//  2 Push 0x11,0x22,0x33,0x44, pop -> next cycle r_data=0x44332211, r_data_valid=1, level=0.
//  3 Push 16 words -> w_full=1, level=16; 17th push dropped; pops return data in order.
//  4 Push 3 words, r_en=1 -> no pop, ext_mem_r_en=0, r_empty stays 1 until 4th push.
//  5 level=8, push+pop same cycle -> level=5; with level=16 push+pop -> level=12, push lost.
//  6 Stream 100 words continuous push/pop -> pointers wrap, no loss/reorder; rst=1 mid-stream
//    -> level=0, r_empty=1, r_data_valid=0 next cycle.

Source files
------------

// File: rtl/iob_asym_fifo_w_narrow_r_wide_ctrl_pkg.sv
// Shared helpers for the narrow-write / wide-read FIFO controller:
// min/max helpers and the width-ratio derivation used by the top and level counter.
package iob_asym_fifo_w_narrow_r_wide_ctrl_pkg;

    // Larger of two integers, used when sizing derived widths.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Smaller of two integers, used when sizing derived widths.
    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Number of address bits folded away when RATIO narrow words make one wide word.
    function automatic int log2_ratio(input int w_width, input int r_width);
        return $clog2(r_width / w_width);
    endfunction

endpackage

// File: rtl/iob_asym_fifo_w_narrow_r_wide_ctrl_level.sv
// Occupancy counter for the asymmetric FIFO: counts narrow words, +1 per push,
// -RATIO per pop, and registers the full/empty flags from the next-cycle level.
module iob_asym_fifo_w_narrow_r_wide_ctrl_level
    import iob_asym_fifo_w_narrow_r_wide_ctrl_pkg::*;
#(
    parameter int W_ADDR_W = 6,
    parameter int RATIO    = 4
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              rst,
    input  logic              inc,
    input  logic              dec,
    output logic [W_ADDR_W:0] level,
    output logic              full,
    output logic              empty
);

    localparam int LVL_W = W_ADDR_W + 1;
    localparam logic [LVL_W-1:0] DEPTH   = LVL_W'(2 ** W_ADDR_W);
    localparam logic [LVL_W-1:0] DEC_AMT = LVL_W'(max_int(RATIO, 1));

    logic [LVL_W-1:0] level_nxt;

    // Next level: callers only assert inc when not full and dec when at least
    // RATIO words are stored, so the count never wraps in either direction.
    always_comb begin
        level_nxt = level;
        if (inc) begin
            level_nxt = level_nxt + LVL_W'(1);
        end
        if (dec) begin
            level_nxt = level_nxt - DEC_AMT;
        end
    end

    // Level and flags registered together so the flags always describe the stored level.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            level <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else if (rst) begin
            level <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            level <= level_nxt;
            full  <= (level_nxt == DEPTH);
            empty <= (level_nxt < DEC_AMT);
        end
    end

endmodule

// File: rtl/iob_asym_fifo_w_narrow_r_wide_ctrl.sv
// Single-clock FIFO controller driving an external narrow-write / wide-read RAM.
// Owns the write/read pointers, the read-valid strobe and the occupancy counter.
module iob_asym_fifo_w_narrow_r_wide_ctrl
    import iob_asym_fifo_w_narrow_r_wide_ctrl_pkg::*;
#(
    parameter int   W_DATA_W = 8,
    parameter int   R_DATA_W = 32,
    parameter int   W_ADDR_W = 6,
    localparam int  R_ADDR_W = W_ADDR_W - log2_ratio(W_DATA_W, R_DATA_W)
) (
    input  logic                clk,
    input  logic                arst_n,
    input  logic                rst,
    input  logic                w_en,
    input  logic [W_DATA_W-1:0] w_data,
    output logic                w_full,
    input  logic                r_en,
    output logic [R_DATA_W-1:0] r_data,
    output logic                r_data_valid,
    output logic                r_empty,
    output logic [W_ADDR_W:0]   level,
    output logic                ext_mem_w_en,
    output logic [W_ADDR_W-1:0] ext_mem_w_addr,
    output logic [W_DATA_W-1:0] ext_mem_w_data,
    output logic                ext_mem_r_en,
    output logic [R_ADDR_W-1:0] ext_mem_r_addr,
    input  logic [R_DATA_W-1:0] ext_mem_r_data
);

    localparam int LOG2_RATIO = log2_ratio(W_DATA_W, R_DATA_W);
    localparam int RATIO      = 1 << LOG2_RATIO;

    logic [W_ADDR_W-1:0] w_ptr;
    logic [R_ADDR_W-1:0] r_ptr;
    logic                push;
    logic                pop;

    // Flags are pre-cycle: a push while full is dropped even if a pop frees room this cycle.
    assign push = w_en & ~w_full;
    assign pop  = r_en & ~r_empty;

    assign ext_mem_w_en   = push;
    assign ext_mem_w_addr = w_ptr;
    assign ext_mem_w_data = w_data;
    assign ext_mem_r_en   = pop;
    assign ext_mem_r_addr = r_ptr;
    assign r_data         = ext_mem_r_data;

    // Pointers wrap naturally; the read pointer addresses whole wide words.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            w_ptr <= '0;
            r_ptr <= '0;
        end else if (rst) begin
            w_ptr <= '0;
            r_ptr <= '0;
        end else begin
            if (push) begin
                w_ptr <= w_ptr + W_ADDR_W'(1);
            end
            if (pop) begin
                r_ptr <= r_ptr + R_ADDR_W'(1);
            end
        end
    end

    // The RAM read is registered, so read data is valid exactly one cycle after a pop.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_data_valid <= 1'b0;
        end else if (rst) begin
            r_data_valid <= 1'b0;
        end else begin
            r_data_valid <= pop;
        end
    end

    iob_asym_fifo_w_narrow_r_wide_ctrl_level #(
        .W_ADDR_W (W_ADDR_W),
        .RATIO    (RATIO)
    ) u_level (
        .clk    (clk),
        .arst_n (arst_n),
        .rst    (rst),
        .inc    (push),
        .dec    (pop),
        .level  (level),
        .full   (w_full),
        .empty  (r_empty)
    );

endmodule

// File: tb/tb_iob_asym_fifo_w_narrow_r_wide_ctrl.sv
// Bench for the asymmetric FIFO controller wrapped with a behavioural
// 8-bit-write / 32-bit-read RAM (16 narrow words).
module tb_iob_asym_fifo_w_narrow_r_wide_ctrl;

    localparam int W_DATA_W = 8;
    localparam int R_DATA_W = 32;
    localparam int W_ADDR_W = 4;
    localparam int R_ADDR_W = 2;

    logic                clk = 1'b0;
    logic                arst_n;
    logic                rst;
    logic                w_en;
    logic [W_DATA_W-1:0] w_data;
    logic                w_full;
    logic                r_en;
    logic [R_DATA_W-1:0] r_data;
    logic                r_data_valid;
    logic                r_empty;
    logic [W_ADDR_W:0]   level;
    logic                ext_mem_w_en;
    logic [W_ADDR_W-1:0] ext_mem_w_addr;
    logic [W_DATA_W-1:0] ext_mem_w_data;
    logic                ext_mem_r_en;
    logic [R_ADDR_W-1:0] ext_mem_r_addr;
    logic [R_DATA_W-1:0] ext_mem_r_data;

    logic [W_DATA_W-1:0] mem [0:15];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        w_en;
        logic [7:0]  w_data;
        logic        r_en;
        logic        exp_mw_en;
        logic        exp_mr_en;
        logic [4:0]  exp_level;
        logic        exp_full;
        logic        exp_empty;
        logic        exp_valid;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    iob_asym_fifo_w_narrow_r_wide_ctrl #(
        .W_DATA_W (W_DATA_W),
        .R_DATA_W (R_DATA_W),
        .W_ADDR_W (W_ADDR_W)
    ) dut (
        .clk            (clk),
        .arst_n         (arst_n),
        .rst            (rst),
        .w_en           (w_en),
        .w_data         (w_data),
        .w_full         (w_full),
        .r_en           (r_en),
        .r_data         (r_data),
        .r_data_valid   (r_data_valid),
        .r_empty        (r_empty),
        .level          (level),
        .ext_mem_w_en   (ext_mem_w_en),
        .ext_mem_w_addr (ext_mem_w_addr),
        .ext_mem_w_data (ext_mem_w_data),
        .ext_mem_r_en   (ext_mem_r_en),
        .ext_mem_r_addr (ext_mem_r_addr),
        .ext_mem_r_data (ext_mem_r_data)
    );

    always #5 clk = ~clk;

    // Behavioural two-port RAM: narrow writes, registered wide read, lane 0 at the lowest address.
    always @(posedge clk) begin
        if (ext_mem_w_en) begin
            mem[ext_mem_w_addr] <= ext_mem_w_data;
        end
        if (ext_mem_r_en) begin
            ext_mem_r_data <= {mem[{ext_mem_r_addr, 2'd3}], mem[{ext_mem_r_addr, 2'd2}],
                               mem[{ext_mem_r_addr, 2'd1}], mem[{ext_mem_r_addr, 2'd0}]};
        end
    end

    function automatic vec_t mk(input logic we, input logic [7:0] wd, input logic re,
                                input logic mw, input logic mr, input logic [4:0] lvl,
                                input logic full, input logic empty, input logic valid,
                                input logic [31:0] rd);
        vec_t v;
        v.w_en = we; v.w_data = wd; v.r_en = re;
        v.exp_mw_en = mw; v.exp_mr_en = mr; v.exp_level = lvl;
        v.exp_full = full; v.exp_empty = empty; v.exp_valid = valid; v.exp_rdata = rd;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [7:0] wd, input logic re, input logic rs);
        w_en   = we;
        w_data = wd;
        r_en   = re;
        rst    = rs;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int mlevel;
        int pushed;
        int popped;
        logic push_ok;
        logic pop_ok;
        logic [31:0] exp_word;
        logic [7:0] q[$];

        // Basic push-4/pop and the partial-group cases.
        vecs.push_back(mk(1, 8'h11, 0, 1, 0, 5'd1, 0, 1, 0, 32'h0));
        vecs.push_back(mk(1, 8'h22, 0, 1, 0, 5'd2, 0, 1, 0, 32'h0));
        vecs.push_back(mk(1, 8'h33, 0, 1, 0, 5'd3, 0, 1, 0, 32'h0));
        vecs.push_back(mk(1, 8'h44, 0, 1, 0, 5'd4, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 5'd0, 0, 1, 1, 32'h44332211));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 5'd0, 0, 1, 0, 32'h0));
        vecs.push_back(mk(1, 8'hA1, 1, 1, 0, 5'd1, 0, 1, 0, 32'h0));
        vecs.push_back(mk(1, 8'hA2, 1, 1, 0, 5'd2, 0, 1, 0, 32'h0));
        vecs.push_back(mk(1, 8'hA3, 1, 1, 0, 5'd3, 0, 1, 0, 32'h0));
        vecs.push_back(mk(1, 8'hA4, 0, 1, 0, 5'd4, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 5'd0, 0, 1, 1, 32'hA4A3A2A1));
        // Fill to 8, push+pop, fill to full, drops at full, then drain.
        for (int i = 0; i < 8; i++) begin
            vecs.push_back(mk(1, 8'(8'hB0 + i), 0, 1, 0, 5'(i + 1), 0, (i + 1) < 4, 0, 32'h0));
        end
        vecs.push_back(mk(1, 8'hC0, 1, 1, 1, 5'd5, 0, 0, 1, 32'hB3B2B1B0));
        for (int i = 0; i < 11; i++) begin
            vecs.push_back(mk(1, 8'(8'hD0 + i), 0, 1, 0, 5'(6 + i), (6 + i) == 16, 0, 0, 32'h0));
        end
        vecs.push_back(mk(1, 8'hFF, 0, 0, 0, 5'd16, 1, 0, 0, 32'h0));
        vecs.push_back(mk(1, 8'hEE, 1, 0, 1, 5'd12, 0, 0, 1, 32'hB7B6B5B4));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 5'd8, 0, 0, 1, 32'hD2D1D0C0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 5'd4, 0, 0, 1, 32'hD6D5D4D3));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 5'd0, 0, 1, 1, 32'hDAD9D8D7));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 5'd0, 0, 1, 0, 32'h0));

        arst_n = 1'b0;
        applyStimulus(0, 8'h00, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        arst_n = 1'b1;
        #1;
        checkOutput("reset_level", 32'(level), 32'd0);
        checkOutput("reset_empty", 32'(r_empty), 32'd1);
        checkOutput("reset_full", 32'(w_full), 32'd0);
        checkOutput("reset_valid", 32'(r_data_valid), 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].w_en, vecs[i].w_data, vecs[i].r_en, 0);
            #1;
            checkOutput($sformatf("v%0d_mem_w_en", i), 32'(ext_mem_w_en), 32'(vecs[i].exp_mw_en));
            checkOutput($sformatf("v%0d_mem_r_en", i), 32'(ext_mem_r_en), 32'(vecs[i].exp_mr_en));
            tick();
            checkOutput($sformatf("v%0d_level", i), 32'(level), 32'(vecs[i].exp_level));
            checkOutput($sformatf("v%0d_full", i), 32'(w_full), 32'(vecs[i].exp_full));
            checkOutput($sformatf("v%0d_empty", i), 32'(r_empty), 32'(vecs[i].exp_empty));
            checkOutput($sformatf("v%0d_valid", i), 32'(r_data_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                checkOutput($sformatf("v%0d_rdata", i), r_data, vecs[i].exp_rdata);
            end
        end

        // Continuous push/pop stream of 100 words against a byte-queue model.
        mlevel = 0;
        pushed = 0;
        popped = 0;
        for (int cyc = 0; cyc < 400 && !(pushed == 100 && mlevel == 0); cyc++) begin
            applyStimulus(pushed < 100, 8'(pushed * 7 + 3), 1, 0);
            push_ok  = w_en && (mlevel != 16);
            pop_ok   = (mlevel >= 4);
            exp_word = 32'h0;
            if (pop_ok) begin
                exp_word = {q[3], q[2], q[1], q[0]};
                repeat (4) void'(q.pop_front());
            end
            if (push_ok) begin
                q.push_back(w_data);
                pushed++;
            end
            mlevel = mlevel + int'(push_ok) - 4 * int'(pop_ok);
            tick();
            checkOutput("stream_level", 32'(level), 32'(mlevel));
            checkOutput("stream_valid", 32'(r_data_valid), 32'(pop_ok));
            if (pop_ok) begin
                checkOutput("stream_rdata", r_data, exp_word);
                popped += 4;
            end
        end
        checkOutput("stream_total", 32'(popped), 32'd100);
        applyStimulus(0, 8'h00, 0, 0);
        tick();

        // Synchronous clear while a popped word is still outstanding.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 8'(8'h60 + i), 0, 0);
            tick();
        end
        applyStimulus(0, 8'h00, 1, 0);
        tick();
        checkOutput("pre_rst_valid", 32'(r_data_valid), 32'd1);
        applyStimulus(1, 8'h99, 1, 1);
        tick();
        checkOutput("rst_valid", 32'(r_data_valid), 32'd0);
        checkOutput("rst_level", 32'(level), 32'd0);
        checkOutput("rst_empty", 32'(r_empty), 32'd1);
        checkOutput("rst_full", 32'(w_full), 32'd0);

        // After the clear both pointers restart at zero.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 8'(8'h70 + i), 0, 0);
            #1;
            checkOutput("post_rst_w_addr", 32'(ext_mem_w_addr), 32'(i));
            tick();
        end
        applyStimulus(0, 8'h00, 1, 0);
        #1;
        checkOutput("post_rst_r_addr", 32'(ext_mem_r_addr), 32'd0);
        tick();
        checkOutput("post_rst_valid", 32'(r_data_valid), 32'd1);
        checkOutput("post_rst_rdata", r_data, 32'h73727170);
        applyStimulus(0, 8'h00, 0, 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
